key_debounce_array: RTL and testbench



---
 rtl/key_debounce_array.sv | 120 ++++++++++++
 tb/tb_key_debounce_array.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/key_debounce_array.sv
// Multi-channel push-button debouncer: 2-flop synchroniser, per-key debounce
// counter, and registered press / release / long-press single-cycle pulses.
module key_debounce_array #(
  parameter int unsigned NUM_KEYS   = 4,
  parameter int unsigned CNT_MAX    = 999_999,
  parameter int unsigned LONG_MAX   = 49_999_999,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                system_clk,
  input  logic                system_reset_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] press_flag,
  output logic [NUM_KEYS-1:0] release_flag,
  output logic [NUM_KEYS-1:0] long_flag
);

  localparam int unsigned CNT_W  = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam int unsigned LONG_W = (LONG_MAX > 0) ? $clog2(LONG_MAX + 1) : 1;
  localparam logic [CNT_W-1:0]    CNT_TERM = CNT_W'(CNT_MAX);
  localparam logic [NUM_KEYS-1:0] IDLE     = {NUM_KEYS{ACTIVE_LOW}};

  logic [NUM_KEYS-1:0] sync1_q, sync2_q;
  logic [NUM_KEYS-1:0] sample;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser into one stage.
  // The synchroniser resets to the idle pin level so a key already held at
  // reset release still has to pass through both stages and full qualification.
  always_ff @(posedge system_clk or negedge system_reset_n) begin
    if (!system_reset_n) begin
      sync1_q <= IDLE;
      sync2_q <= IDLE;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  // Polarity-normalised sample: 1 = pressed.
  assign sample = sync2_q ^ IDLE;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;

    // NOTE: every variable gets a default at the top of always_comb, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      if (sample[k] != level_q) begin
        if (cnt_q == CNT_TERM) begin
          level_d = ~level_q;
          press_d = ~level_q;
          rel_d   = level_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge system_clk or negedge system_reset_n) begin
      if (!system_reset_n) begin
        cnt_q   <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end

    assign key_level[k]    = level_q;
    assign press_flag[k]   = press_q;
    assign release_flag[k] = rel_q;

    if (LONG_MAX > 0) begin : g_long
      localparam logic [LONG_W-1:0] HOLD_TERM = LONG_W'(LONG_MAX);
      localparam logic [LONG_W-1:0] HOLD_PRE  = LONG_W'(LONG_MAX - 1);

      logic [LONG_W-1:0] hold_q, hold_d;
      logic              long_q, long_d;

      // Saturating at HOLD_TERM is what limits long_flag to one pulse per press.
      always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (!level_q) begin
          hold_d = '0;
        end else if (hold_q != HOLD_TERM) begin
          hold_d = hold_q + LONG_W'(1);
          long_d = (hold_q == HOLD_PRE);
        end
      end

      always_ff @(posedge system_clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
          hold_q <= '0;
          long_q <= 1'b0;
        end else begin
          hold_q <= hold_d;
          long_q <= long_d;
        end
      end

      assign long_flag[k] = long_q;
    end else begin : g_no_long
      assign long_flag[k] = 1'b0;
    end
  end

endmodule

// File: tb/tb_key_debounce_array.sv
// Directed bench for key_debounce_array (4 keys, CNT_MAX=9, LONG_MAX=50,
// active-low pins). Outputs are sampled 1 ns after each rising edge.
module tb_key_debounce_array;

  typedef struct {
    string      name;
    logic [3:0] key;
    int         cycles;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] lng;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_in;
  logic [3:0] key_level, press_flag, release_flag, long_flag;

  int checks   = 0;
  int failures = 0;

  key_debounce_array #(
    .NUM_KEYS  (4),
    .CNT_MAX   (9),
    .LONG_MAX  (50),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .system_clk    (clk),
    .system_reset_n(rst_n),
    .key_in        (key_in),
    .key_level     (key_level),
    .press_flag    (press_flag),
    .release_flag  (release_flag),
    .long_flag     (long_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive v.key, run v.cycles edges; flags must stay low on all but the last
  // edge, and the last edge must show exactly the expected outputs.
  task automatic run_vec(input vec_t v);
    logic [3:0] acc;
    acc    = '0;
    key_in = v.key;
    for (int i = 0; i < v.cycles; i++) begin
      tick();
      if (i != v.cycles - 1) acc = acc | press_flag | release_flag | long_flag;
    end
    if (v.cycles > 1) check({v.name, " quiet"}, 32'(acc), 32'h0);
    check({v.name, " level"},   32'(key_level),    32'(v.lvl));
    check({v.name, " press"},   32'(press_flag),   32'(v.prs));
    check({v.name, " release"}, 32'(release_flag), 32'(v.rel));
    check({v.name, " long"},    32'(long_flag),    32'(v.lng));
  endtask

  vec_t tbl[16];

  initial begin
    logic [3:0] acc;

    //          name            key    cyc lvl    prs    rel    lng
    tbl[0]  = '{"press0",       4'hE,  12, 4'h1,  4'h1,  4'h0,  4'h0};
    tbl[1]  = '{"press0_width", 4'hE,   1, 4'h1,  4'h0,  4'h0,  4'h0};
    tbl[2]  = '{"release0",     4'hF,  12, 4'h0,  4'h0,  4'h1,  4'h0};
    tbl[3]  = '{"idle_a",       4'hF,   1, 4'h0,  4'h0,  4'h0,  4'h0};
    tbl[4]  = '{"press13",      4'h5,  12, 4'hA,  4'hA,  4'h0,  4'h0};
    tbl[5]  = '{"swap1_0",      4'h6,  12, 4'h9,  4'h1,  4'h2,  4'h0};
    tbl[6]  = '{"release03",    4'hF,  12, 4'h0,  4'h0,  4'h9,  4'h0};
    tbl[7]  = '{"idle_b",       4'hF,   3, 4'h0,  4'h0,  4'h0,  4'h0};
    tbl[8]  = '{"press2",       4'hB,  12, 4'h4,  4'h4,  4'h0,  4'h0};
    tbl[9]  = '{"long2",        4'hB,  50, 4'h4,  4'h0,  4'h0,  4'h4};
    tbl[10] = '{"hold2_nolong", 4'hB,  38, 4'h4,  4'h0,  4'h0,  4'h0};
    tbl[11] = '{"release2",     4'hF,  12, 4'h0,  4'h0,  4'h4,  4'h0};
    tbl[12] = '{"press2_short", 4'hB,  12, 4'h4,  4'h4,  4'h0,  4'h0};
    tbl[13] = '{"hold2_30",     4'hB,  30, 4'h4,  4'h0,  4'h0,  4'h0};
    tbl[14] = '{"release2_sh",  4'hF,  12, 4'h0,  4'h0,  4'h4,  4'h0};
    tbl[15] = '{"idle_c",       4'hF,   1, 4'h0,  4'h0,  4'h0,  4'h0};

    // Reset idle: keys released, reset held 5 cycles, then 100 quiet cycles.
    rst_n  = 1'b0;
    key_in = 4'hF;
    repeat (5) @(posedge clk);
    #1;
    check("in_reset outputs", 32'({key_level, press_flag, release_flag, long_flag}), 32'h0);
    rst_n = 1'b1;
    acc = '0;
    for (int i = 0; i < 100; i++) begin
      tick();
      acc = acc | key_level | press_flag | release_flag | long_flag;
    end
    check("reset_idle outputs", 32'(acc), 32'h0);

    // Directed table: clean press, simultaneous channels, long press.
    for (int i = 0; i < 16; i++) run_vec(tbl[i]);

    // Bounce: 8 low / 2 high never reaches 10 stable samples.
    acc = '0;
    for (int r = 0; r < 5; r++) begin
      key_in = 4'hE;
      repeat (8) begin
        tick();
        acc = acc | key_level | press_flag | release_flag | long_flag;
      end
      key_in = 4'hF;
      repeat (2) begin
        tick();
        acc = acc | key_level | press_flag | release_flag | long_flag;
      end
    end
    check("bounce outputs", 32'(acc), 32'h0);
    run_vec('{"bounce_settle", 4'hE, 12, 4'h1, 4'h1, 4'h0, 4'h0});
    run_vec('{"bounce_release", 4'hF, 12, 4'h0, 4'h0, 4'h1, 4'h0});

    // Reset in the middle of key 0's hold count.
    run_vec('{"mid_press0", 4'hE, 12, 4'h1, 4'h1, 4'h0, 4'h0});
    run_vec('{"mid_hold0", 4'hE, 20, 4'h1, 4'h0, 4'h0, 4'h0});
    rst_n = 1'b0;
    #1;
    check("async_reset outputs", 32'({key_level, press_flag, release_flag, long_flag}), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("held_reset outputs", 32'({key_level, press_flag, release_flag, long_flag}), 32'h0);
    rst_n = 1'b1;
    run_vec('{"post_reset_press0", 4'hE, 12, 4'h1, 4'h1, 4'h0, 4'h0});
    run_vec('{"post_reset_long0", 4'hE, 50, 4'h1, 4'h0, 4'h0, 4'h1});
    run_vec('{"post_reset_rel0", 4'hF, 12, 4'h0, 4'h0, 4'h1, 4'h0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
